// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: classifies an RV32/RV64 instruction, builds the
// XLEN-wide immediate and pc-relative target, with valid/ready and optional skid buffer.
module imm_decode_stage #(
  parameter int          XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  // Handshake: a beat moves across a port on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a held beat stays stable until taken.

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;

  localparam logic [2:0] FMT_B    = 3'b000;
  localparam logic [2:0] FMT_I    = 3'b001;
  localparam logic [2:0] FMT_S    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
  localparam logic [2:0] FMT_Z    = 3'b101;
  localparam logic [2:0] FMT_SH   = 3'b110;
  localparam logic [2:0] FMT_NONE = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } beat_t;

  localparam beat_t BEAT_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, pc: '0, target: '0};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift_f3;
  logic            wide_shamt;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh;
  logic [XLEN-1:0] dec_imm;
  beat_t           dec_beat;

  assign opcode      = in_instr[6:0];
  assign funct3      = in_instr[14:12];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Only the 64-bit OP-IMM shift carries a 6-bit shamt; OP-IMM-32 stays at 5 bits.
  assign wide_shamt  = (XLEN == 64) && (opcode == OP_OP_IMM);

  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: dec_fmt = FMT_I;
      OP_OP_IMM:        dec_fmt = is_shift_f3 ? FMT_SH : FMT_I;
      OP_STORE:         dec_fmt = FMT_S;
      OP_BRANCH:        dec_fmt = FMT_B;
      OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
      OP_JAL:           dec_fmt = FMT_J;
      OP_SYSTEM:        dec_fmt = funct3[2] ? FMT_Z : FMT_I;
      OP_OP:            dec_fmt = FMT_NONE;
      OP_OP_IMM_32: begin
        if (XLEN == 64) dec_fmt = is_shift_f3 ? FMT_SH : FMT_I;
        else            dec_illegal = 1'b1;
      end
      OP_OP_32: begin
        if (XLEN != 64) dec_illegal = 1'b1;
      end
      default:          dec_illegal = 1'b1;
    endcase
  end

  // Each candidate starts as all sign (or zero) bits, then the low field is overlaid.
  always_comb begin
    imm_i        = {XLEN{in_instr[31]}};
    imm_i[11:0]  = in_instr[31:20];
    imm_s        = {XLEN{in_instr[31]}};
    imm_s[11:0]  = {in_instr[31:25], in_instr[11:7]};
    imm_b        = {XLEN{in_instr[31]}};
    imm_b[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u        = {XLEN{in_instr[31]}};
    imm_u[31:0]  = {in_instr[31:12], 12'b0};
    imm_j        = {XLEN{in_instr[31]}};
    imm_j[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    imm_z        = '0;
    imm_z[4:0]   = in_instr[19:15];
    imm_sh       = '0;
    imm_sh[4:0]  = in_instr[24:20];
    if (wide_shamt) imm_sh[5] = in_instr[25];
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_B:   dec_imm = imm_b;
      FMT_I:   dec_imm = imm_i;
      FMT_S:   dec_imm = imm_s;
      FMT_U:   dec_imm = imm_u;
      FMT_J:   dec_imm = imm_j;
      FMT_Z:   dec_imm = imm_z;
      FMT_SH:  dec_imm = imm_sh;
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec_beat         = BEAT_RESET;
    dec_beat.imm     = dec_imm;
    dec_beat.fmt     = dec_fmt;
    dec_beat.illegal = dec_illegal;
    dec_beat.pc      = in_pc;
    dec_beat.target  = in_pc + dec_imm;
  end

  // Holding registers: main drives the outputs, skid catches one beat during a stall.
  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  main_free;
  logic  accept;

  assign main_free = !main_valid_q || out_ready;
  assign in_ready  = (SKID != 0) ? !skid_valid_q : main_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so nothing new can arrive; skid refills main first.
      if (main_free) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_d       = dec_beat;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec_beat;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= BEAT_RESET;
      skid_q       <= BEAT_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;
  assign out_target  = main_q.target;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: RV32 with skid buffer and RV64 without, directed steps
// followed by a randomized stream scored against a reference decoder and beat queue.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_in_pc, a_out_imm, a_out_pc, a_out_target;
  logic [2:0]  a_out_fmt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr;
  logic [63:0] b_in_pc, b_out_imm, b_out_pc, b_out_target;
  logic [2:0]  b_out_fmt;

  imm_decode_stage #(.XLEN(32), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_pc(a_out_pc),
    .out_target(a_out_target)
  );

  imm_decode_stage #(.XLEN(64), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_pc(b_out_pc),
    .out_target(b_out_target)
  );

  int tests_run = 0;
  int fail_count = 0;

  // Expected beat packing: {imm[63:0], fmt[2:0], illegal, pc[63:0], target[63:0]}.
  logic [195:0] exp_a_q[$];
  logic [195:0] exp_b_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    a_in_valid = v;
    a_in_instr = instr;
    a_in_pc    = pc;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    b_in_valid = v;
    b_in_instr = instr;
    b_in_pc    = pc;
  endtask

  // Reference decoder: field placement done with arithmetic shifts on the sign-extended word.
  function automatic logic [195:0] model(input int xlen, input logic [31:0] ins,
                                         input logic [63:0] pc);
    logic signed [63:0] s, t;
    logic [63:0] imm, tgt;
    logic [6:0]  op;
    logic [2:0]  f3, fmt;
    logic        ill;
    s   = $signed(ins);
    op  = ins[6:0];
    f3  = ins[14:12];
    ill = 1'b0;
    fmt = 3'd7;
    case (op)
      7'h03, 7'h67: fmt = 3'd1;
      7'h13:        fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
      7'h23:        fmt = 3'd2;
      7'h63:        fmt = 3'd0;
      7'h37, 7'h17: fmt = 3'd3;
      7'h6F:        fmt = 3'd4;
      7'h73:        fmt = (f3 >= 3'd4) ? 3'd5 : 3'd1;
      7'h33:        fmt = 3'd7;
      7'h1B: if (xlen == 64) fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1; else ill = 1'b1;
      7'h3B: if (xlen != 64) ill = 1'b1;
      default:      ill = 1'b1;
    endcase
    imm = 64'd0;
    case (fmt)
      3'd1: imm = s >>> 20;
      3'd2: begin t = s >>> 25; imm = (t << 5) | 64'(ins[11:7]); end
      3'd0: begin
        t = s >>> 31;
        imm = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      3'd3: imm = (s >>> 12) << 12;
      3'd4: begin
        t = s >>> 31;
        imm = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      3'd5: imm = 64'(ins[19:15]);
      3'd6: imm = (xlen == 64 && op == 7'h13) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: imm = 64'd0;
    endcase
    tgt = pc + imm;
    if (xlen == 32) begin
      imm = imm & 64'hFFFF_FFFF;
      tgt = tgt & 64'hFFFF_FFFF;
    end
    return {imm, fmt, ill, pc, tgt};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[14] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h73, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h0B};
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 13)]};
  endfunction

  task automatic check_beat_a(input string tag, input logic [195:0] e);
    check({tag, "_imm"},    64'(a_out_imm),     e[195:132]);
    check({tag, "_fmt"},    64'(a_out_fmt),     64'(e[131:129]));
    check({tag, "_ill"},    64'(a_out_illegal), 64'(e[128]));
    check({tag, "_pc"},     64'(a_out_pc),      e[127:64]);
    check({tag, "_target"}, 64'(a_out_target),  e[63:0]);
  endtask

  task automatic check_beat_b(input string tag, input logic [195:0] e);
    check({tag, "_imm"},    b_out_imm,          e[195:132]);
    check({tag, "_fmt"},    64'(b_out_fmt),     64'(e[131:129]));
    check({tag, "_ill"},    64'(b_out_illegal), 64'(e[128]));
    check({tag, "_pc"},     b_out_pc,           e[127:64]);
    check({tag, "_target"}, b_out_target,       e[63:0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_valid"},  64'(a_out_valid), 64'd0);
    check({tag, "_a_ready"},  64'(a_in_ready),  64'd1);
    check_beat_a({tag, "_a"}, {64'd0, 3'd7, 1'b0, 64'd0, 64'd0});
    check({tag, "_b_valid"},  64'(b_out_valid), 64'd0);
    check({tag, "_b_ready"},  64'(b_in_ready),  64'd1);
    check_beat_b({tag, "_b"}, {64'd0, 3'd7, 1'b0, 64'd0, 64'd0});
  endtask

  initial begin
    a_flush = 0; a_out_ready = 1; drive_a(0, 32'd0, 32'd0);
    b_flush = 0; b_out_ready = 1; drive_b(0, 32'd0, 64'd0);

    // Reset state
    tick(); tick();
    check_reset_values("reset");
    rst_n = 1'b1;

    // RV32 directed decode, back-to-back
    drive_a(1, 32'hFFF00093, 32'h100);
    tick();
    check("addi_valid",  64'(a_out_valid),   64'd1);
    check("addi_fmt",    64'(a_out_fmt),     64'd1);
    check("addi_imm",    64'(a_out_imm),     64'hFFFF_FFFF);
    check("addi_target", 64'(a_out_target),  64'h0000_00FF);
    check("addi_ill",    64'(a_out_illegal), 64'd0);
    drive_a(1, 32'hFE000EE3, 32'h100);
    tick();
    check("beq_fmt",     64'(a_out_fmt),     64'd0);
    check("beq_imm",     64'(a_out_imm),     64'hFFFF_FFFC);
    check("beq_target",  64'(a_out_target),  64'h0000_00FC);
    drive_a(1, 32'h4030D093, 32'h104);
    tick();
    check("srai_fmt",    64'(a_out_fmt),     64'd6);
    check("srai_imm",    64'(a_out_imm),     64'd3);
    drive_a(0, 32'd0, 32'd0);
    tick();
    check("drain_valid", 64'(a_out_valid),   64'd0);

    // RV64 directed decode (no skid)
    drive_b(1, 32'h800000B7, 64'h1000);
    tick();
    check("lui_fmt",     64'(b_out_fmt),     64'd3);
    check("lui_imm",     b_out_imm,          64'hFFFF_FFFF_8000_0000);
    check("lui_target",  b_out_target,       64'hFFFF_FFFF_8000_1000);
    drive_b(1, 32'h340FD073, 64'h2000);
    tick();
    check("csrrwi_fmt",  64'(b_out_fmt),     64'd5);
    check("csrrwi_imm",  b_out_imm,          64'd31);
    drive_b(1, 32'h0000007F, 64'h3000);
    tick();
    check("bad_ill",     64'(b_out_illegal), 64'd1);
    check("bad_imm",     b_out_imm,          64'd0);
    check("bad_fmt",     64'(b_out_fmt),     64'd7);
    drive_b(1, 32'h02109093, 64'h4000);
    tick();
    check("slli33_fmt",  64'(b_out_fmt),     64'd6);
    check("slli33_imm",  b_out_imm,          64'd33);

    // RV64 no-skid: ready drops under stall, flush discards the beat accepted with it
    b_out_ready = 0;
    drive_b(1, 32'h00100093, 64'h5000);
    tick();
    check("b_stall_ready", 64'(b_in_ready),  64'd0);
    b_out_ready = 1;
    b_flush = 1;
    drive_b(1, 32'h00200093, 64'h5004);
    #1;
    check("b_flush_ready", 64'(b_in_ready),  64'd1);
    tick();
    b_flush = 0;
    drive_b(0, 32'd0, 64'd0);
    check("b_flush_valid", 64'(b_out_valid), 64'd0);
    tick();
    check("b_flush_gone",  64'(b_out_valid), 64'd0);

    // RV32 skid: A held, B in skid, C stalled, then delivered in order
    a_out_ready = 0;
    drive_a(1, 32'hFFF00093, 32'h200);
    tick();
    check("skid_a_ready1", 64'(a_in_ready),  64'd1);
    drive_a(1, 32'hFE000EE3, 32'h204);
    tick();
    check("skid_ready_low", 64'(a_in_ready), 64'd0);
    check("skid_hold_pc1",  64'(a_out_pc),   64'h200);
    drive_a(1, 32'h4030D093, 32'h208);
    tick();
    check("skid_hold_pc2",  64'(a_out_pc),   64'h200);
    check("skid_hold_imm",  64'(a_out_imm),  64'hFFFF_FFFF);
    check("skid_ready_low2", 64'(a_in_ready), 64'd0);
    tick();
    check("skid_hold_pc3",  64'(a_out_pc),   64'h200);
    a_out_ready = 1;
    #1;
    check("order_a_pc",     64'(a_out_pc),   64'h200);
    tick();
    check("order_b_pc",     64'(a_out_pc),   64'h204);
    check("order_b_fmt",    64'(a_out_fmt),  64'd0);
    check("ready_back",     64'(a_in_ready), 64'd1);
    tick();
    drive_a(0, 32'd0, 32'd0);
    check("order_c_pc",     64'(a_out_pc),   64'h208);
    check("order_c_imm",    64'(a_out_imm),  64'd3);
    tick();
    check("order_empty",    64'(a_out_valid), 64'd0);

    // RV32 flush with main and skid full and a beat presented
    a_out_ready = 0;
    drive_a(1, 32'h00100093, 32'h300);
    tick();
    drive_a(1, 32'h00200093, 32'h304);
    tick();
    drive_a(1, 32'h00300093, 32'h308);
    a_flush = 1;
    tick();
    a_flush = 0;
    drive_a(0, 32'd0, 32'd0);
    check("flush1_valid",   64'(a_out_valid), 64'd0);
    check("flush1_ready",   64'(a_in_ready),  64'd1);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush1_gone",  64'(a_out_valid), 64'd0);
    end

    // RV32 flush with a beat accepted in the same cycle
    a_out_ready = 0;
    drive_a(1, 32'h00400093, 32'h310);
    tick();
    drive_a(1, 32'h00500093, 32'h314);
    a_flush = 1;
    #1;
    check("flush2_ready",   64'(a_in_ready),  64'd1);
    tick();
    a_flush = 0;
    drive_a(0, 32'd0, 32'd0);
    check("flush2_valid",   64'(a_out_valid), 64'd0);
    a_out_ready = 1;
    tick(); tick();
    check("flush2_gone",    64'(a_out_valid), 64'd0);

    // Asynchronous reset mid-stream
    a_out_ready = 0; b_out_ready = 0;
    drive_a(1, 32'h00600093, 32'h400);
    drive_b(1, 32'h00600093, 64'h400);
    tick();
    drive_a(1, 32'h00700093, 32'h404);
    drive_b(0, 32'd0, 64'd0);
    tick();
    drive_a(0, 32'd0, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_out_ready = 1; b_out_ready = 1;
    tick();
    check("post_rst_a_valid", 64'(a_out_valid), 64'd0);
    check("post_rst_b_valid", 64'(b_out_valid), 64'd0);

    // Randomized stream against the reference model and beat queues
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_a($urandom_range(0, 3) != 0, rand_instr(), $urandom);
      a_out_ready = $urandom_range(0, 2) != 0;
      a_flush     = $urandom_range(0, 40) == 0;
      drive_b($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom});
      b_out_ready = $urandom_range(0, 2) != 0;
      b_flush     = $urandom_range(0, 40) == 0;
      @(negedge clk);

      check("rand_a_ready", 64'(a_in_ready),  64'(exp_a_q.size() < 2));
      check("rand_a_valid", 64'(a_out_valid), 64'(exp_a_q.size() != 0));
      if (a_out_valid && exp_a_q.size() != 0) check_beat_a("rand_a", exp_a_q[0]);
      if (a_flush) exp_a_q.delete();
      else begin
        if (a_out_valid && a_out_ready && exp_a_q.size() != 0) void'(exp_a_q.pop_front());
        if (a_in_valid && a_in_ready) exp_a_q.push_back(model(32, a_in_instr, 64'(a_in_pc)));
      end

      check("rand_b_ready", 64'(b_in_ready),  64'(exp_b_q.size() == 0 || b_out_ready));
      check("rand_b_valid", 64'(b_out_valid), 64'(exp_b_q.size() != 0));
      if (b_out_valid && exp_b_q.size() != 0) check_beat_b("rand_b", exp_b_q[0]);
      if (b_flush) exp_b_q.delete();
      else begin
        if (b_out_valid && b_out_ready && exp_b_q.size() != 0) void'(exp_b_q.pop_front());
        if (b_in_valid && b_in_ready) exp_b_q.push_back(model(64, b_in_instr, b_in_pc));
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
